bnn_maxpool: RTL

2x2/stride-2 binary max-pool stage directly downstream of the BNN conv layer. It reads the conv layer's binarized output BRAM, one 26-bit row word per channel row. It ORs each 2x2 window, which is max-pooling for {0,1} activations. It writes 13-bit pooled row words to a pool output BRAM that feeds the next layer.

---
 rtl/bnn_maxpool.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/bnn_maxpool.sv
// 2x2/stride-2 binary max-pool: ORs row pairs from the conv output BRAM and writes pooled words.
// Optional BNN_MAXPOOL_ONES_CNT_EN adds o_ones_cnt, a running popcount of the words written in a run.
module bnn_maxpool #(
    parameter int IN_MEM_DWIDTH  = 26,
    parameter int IN_MEM_AWIDTH  = 7,
    parameter int ROWS           = 26,
    parameter int CHANNEL        = 3,
    parameter int IN_MEM_DEPTH   = ROWS * CHANNEL,
    parameter int OUT_MEM_DWIDTH = IN_MEM_DWIDTH / 2,
    parameter int OUT_MEM_AWIDTH = 6,
    parameter int OUT_MEM_DEPTH  = IN_MEM_DEPTH / 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_run,
    output logic                      o_idle,
    output logic                      o_read,
    output logic                      o_write,
    output logic                      o_done,
    output logic [IN_MEM_AWIDTH-1:0]  addr_input,
    output logic                      ce_input,
    output logic                      we_input,
    input  logic [IN_MEM_DWIDTH-1:0]  q_input,
    output logic [OUT_MEM_AWIDTH-1:0] addr_output,
    output logic                      ce_output,
    output logic                      we_output,
    output logic [OUT_MEM_DWIDTH-1:0] d_output
`ifdef BNN_MAXPOOL_ONES_CNT_EN
    ,
    output logic [8:0]                o_ones_cnt
`endif
);

    localparam logic [IN_MEM_AWIDTH-1:0]  LAST_IN_ADDR  = IN_MEM_AWIDTH'(IN_MEM_DEPTH - 1);
    localparam logic [OUT_MEM_AWIDTH-1:0] LAST_OUT_ADDR = OUT_MEM_AWIDTH'(OUT_MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic                      drain_cnt;
    logic                      run_accept;
    logic                      rd_valid;
    logic                      rd_odd;
    logic [IN_MEM_DWIDTH-1:0]  even_row;
    logic [IN_MEM_DWIDTH-1:0]  pair_or;
    logic [OUT_MEM_DWIDTH-1:0] pooled;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        o_idle     = 1'b0;
        o_read     = 1'b0;
        o_done     = 1'b0;
        case (state)
            S_IDLE: begin
                o_idle = 1'b1;
                if (i_run) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                o_read = 1'b1;
                if (addr_input == LAST_IN_ADDR) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_cnt) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                o_done     = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign run_accept = (state == S_IDLE) && i_run;
    assign ce_input   = o_read;
    assign we_input   = 1'b0;
    assign we_output  = ce_output;
    assign o_write    = ce_output;

    // Two drain cycles let the last read word pass through the read and pool stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            drain_cnt <= 1'b0;
        end else begin
            drain_cnt <= (state == S_DRAIN);
        end
    end

    always_comb begin
        pair_or = even_row | q_input;
        pooled  = '0;
        for (int k = 0; k < OUT_MEM_DWIDTH; k++) begin
            pooled[k] = pair_or[2*k] | pair_or[2*k+1];
        end
    end

    // rd_valid/rd_odd track the address issued last cycle, whose data is on q_input now.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_input  <= '0;
            rd_valid    <= 1'b0;
            rd_odd      <= 1'b0;
            even_row    <= '0;
            ce_output   <= 1'b0;
            d_output    <= '0;
            addr_output <= '0;
        end else begin
            rd_valid <= (state == S_RUN);
            rd_odd   <= addr_input[0];

            if ((state == S_RUN) && (addr_input != LAST_IN_ADDR)) begin
                addr_input <= addr_input + 1'b1;
            end else begin
                addr_input <= '0;
            end

            if (rd_valid && !rd_odd) begin
                even_row <= q_input;
            end

            ce_output <= rd_valid && rd_odd;
            if (rd_valid && rd_odd) begin
                d_output <= pooled;
            end

            if ((state == S_DONE) || run_accept) begin
                addr_output <= '0;
            end else if (ce_output && (addr_output != LAST_OUT_ADDR)) begin
                addr_output <= addr_output + 1'b1;
            end
        end
    end

`ifdef BNN_MAXPOOL_ONES_CNT_EN
    logic [8:0] word_ones;

    always_comb begin
        word_ones = '0;
        for (int i = 0; i < OUT_MEM_DWIDTH; i++) begin
            word_ones = word_ones + 9'(d_output[i]);
        end
    end

    // Counts each word while it is being written; holds after the run until the next start.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_ones_cnt <= '0;
        end else if (run_accept) begin
            o_ones_cnt <= '0;
        end else if (ce_output) begin
            o_ones_cnt <= o_ones_cnt + word_ones;
        end
    end
`endif

endmodule
